// File: rtl/motor_cmd.sv
// Motor command sequencer: debounces fwd/rev/stop buttons and drives pwm enable/direct,
// forcing a fixed brake interval with enable low around every reversal and stop.
module motor_cmd #(
    parameter int DEB_CNT  = 1_000_000,
    parameter int DEAD_CNT = 25_000_000
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic       key_fwd,
    input  logic       key_rev,
    input  logic       key_stop,
    output logic       enable,
    output logic       direct,
    output logic [1:0] state
);

    localparam int DW = $clog2(DEB_CNT + 1);
    localparam int TW = $clog2(DEAD_CNT + 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_BRAKE = 2'b10;

    localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CNT);
    localparam logic [DW-1:0] DEB_ARM   = DW'(DEB_CNT - 1);
    localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD_CNT - 1);

    // Bit order everywhere: [2] stop, [1] rev, [0] fwd
    logic [2:0]    key_raw_s;
    logic [2:0]    sync1_r;
    logic [2:0]    sync2_r;
    logic [2:0]    press_r;
    logic [DW-1:0] deb_cnt_r [3];

    logic          stop_s;
    logic          fwd_s;
    logic          rev_s;
    logic          pend_stop_s;
    logic          pend_dir_s;
    logic          pend_stop_r;
    logic          pend_dir_r;
    logic [TW-1:0] dead_cnt_r;

    assign key_raw_s = {key_stop, key_rev, key_fwd};

    // Synchronize, debounce and emit one press pulse per qualified key press
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            sync1_r <= 3'b111;
            sync2_r <= 3'b111;
            press_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_r[i] <= '0;
            end
        end else begin
            sync1_r <= key_raw_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i]) begin
                    deb_cnt_r[i] <= '0;
                    press_r[i]   <= 1'b0;
                end else begin
                    if (deb_cnt_r[i] < DEB_MAX) begin
                        deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
                    end else begin
                        deb_cnt_r[i] <= deb_cnt_r[i];
                    end
                    press_r[i] <= (deb_cnt_r[i] == DEB_ARM);
                end
            end
        end
    end

    // Resolve same-cycle pulses (stop > fwd > rev) and compute the updated pending request
    always_comb begin
        stop_s      = press_r[2];
        fwd_s       = press_r[0] & ~press_r[2];
        rev_s       = press_r[1] & ~press_r[2] & ~press_r[0];
        pend_stop_s = pend_stop_r;
        pend_dir_s  = pend_dir_r;
        if (stop_s) begin
            pend_stop_s = 1'b1;
        end else if (fwd_s) begin
            pend_stop_s = 1'b0;
            pend_dir_s  = 1'b1;
        end else if (rev_s) begin
            pend_stop_s = 1'b0;
            pend_dir_s  = 1'b0;
        end else begin
            pend_stop_s = pend_stop_r;
            pend_dir_s  = pend_dir_r;
        end
    end

    // Sequencer: direct only ever changes on an edge where enable was already low
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state       <= ST_IDLE;
            enable      <= 1'b0;
            direct      <= 1'b1;
            pend_stop_r <= 1'b1;
            pend_dir_r  <= 1'b1;
            dead_cnt_r  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fwd_s) begin
                        state  <= ST_RUN;
                        enable <= 1'b1;
                        direct <= 1'b1;
                    end else if (rev_s) begin
                        state  <= ST_RUN;
                        enable <= 1'b1;
                        direct <= 1'b0;
                    end else begin
                        state  <= ST_IDLE;
                        enable <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stop_s || (fwd_s && !direct) || (rev_s && direct)) begin
                        state       <= ST_BRAKE;
                        enable      <= 1'b0;
                        dead_cnt_r  <= '0;
                        pend_stop_r <= pend_stop_s;
                        pend_dir_r  <= pend_dir_s;
                    end else begin
                        state  <= ST_RUN;
                        enable <= 1'b1;
                    end
                end
                ST_BRAKE: begin
                    pend_stop_r <= pend_stop_s;
                    pend_dir_r  <= pend_dir_s;
                    if (dead_cnt_r == DEAD_LAST) begin
                        dead_cnt_r <= '0;
                        if (pend_stop_s) begin
                            state  <= ST_IDLE;
                            enable <= 1'b0;
                        end else begin
                            state  <= ST_RUN;
                            enable <= 1'b1;
                            direct <= pend_dir_s;
                        end
                    end else begin
                        dead_cnt_r <= dead_cnt_r + TW'(1);
                        enable     <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    enable     <= 1'b0;
                    dead_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule
